// File: rtl/mc_alu.sv
// Registered EX-stage ALU with a multi-cycle restoring divider behind a valid/ready handshake.
// Optional multiplier ops (MUL, MULH) are built only when MC_ALU_MUL_EN is defined.
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOR  = 5'h06;
    localparam logic [4:0] OP_SLL  = 5'h07;
    localparam logic [4:0] OP_SRL  = 5'h08;
    localparam logic [4:0] OP_SRA  = 5'h09;
    localparam logic [4:0] OP_LUI  = 5'h0A;
    localparam logic [4:0] OP_SLT  = 5'h0B;
    localparam logic [4:0] OP_SLTU = 5'h0C;
    localparam logic [4:0] OP_DIV  = 5'h0D;
    localparam logic [4:0] OP_DIVU = 5'h0E;
    localparam logic [4:0] OP_REM  = 5'h0F;
    localparam logic [4:0] OP_REMU = 5'h10;
`ifdef MC_ALU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'h11;
    localparam logic [4:0] OP_MULH = 5'h12;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_e;

    state_e           state_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [4:0]       op_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;

    logic [SHW-1:0]   shamt;
    logic             is_div_op;
    logic             signed_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             step_ok;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_DIV) || (state_q == S_FIN);
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;

    assign shamt      = alu_a[SHW-1:0];
    assign is_div_op  = alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign signed_div = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign a_neg      = signed_div && alu_a[WIDTH-1];
    assign b_neg      = signed_div && alu_b[WIDTH-1];
    assign a_mag      = a_neg ? -alu_a : alu_a;
    assign b_mag      = b_neg ? -alu_b : alu_b;

`ifdef MC_ALU_MUL_EN
    logic signed [2*WIDTH-1:0] prod;
    assign prod = $signed(alu_a) * $signed(alu_b);
`endif

    // Divide-by-zero REM/REMU returns the dividend; DIV/DIVU by zero fall to the 0 default.
    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        single_res = '0;
        case (alu_op)
            OP_ADD:          single_res = alu_a + alu_b;
            OP_SUB:          single_res = alu_a - alu_b;
            OP_AND:          single_res = alu_a & alu_b;
            OP_OR:           single_res = alu_a | alu_b;
            OP_XOR:          single_res = alu_a ^ alu_b;
            OP_NOR:          single_res = ~(alu_a | alu_b);
            OP_SLL:          single_res = alu_b << shamt;
            OP_SRL:          single_res = alu_b >> shamt;
            OP_SRA:          single_res = $signed(alu_b) >>> shamt;
            OP_LUI:          single_res = {alu_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT:          single_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU:         single_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            OP_REM, OP_REMU: single_res = alu_a;
`ifdef MC_ALU_MUL_EN
            OP_MUL:          single_res = prod[WIDTH-1:0];
            OP_MULH:         single_res = prod[2*WIDTH-1:WIDTH];
`endif
            default:         single_res = '0;
        endcase
    end

    // One restoring step: shift the next dividend bit in, keep the difference if non-negative.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};
    assign step_ok   = !rem_diff[WIDTH];
    assign rem_d     = step_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], step_ok};

    always_comb begin
        fin_res = rem_q;
        case (op_q)
            OP_DIV:  fin_res = qneg_q ? -quo_q : quo_q;
            OP_DIVU: fin_res = quo_q;
            OP_REM:  fin_res = rneg_q ? -rem_q : rem_q;
            default: fin_res = rem_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            op_q        <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_div_op && (alu_b != '0)) begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            dvsr_q  <= b_mag;
                            op_q    <= alu_op;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end else begin
                            alu_out_q   <= single_res;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    alu_out_q   <= fin_res;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu: a 32-bit instance for most vectors and a
// 16-bit instance for the narrow-width cases (MULH expectation follows MC_ALU_MUL_EN).
module tb_mc_alu;

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOR  = 5'h06;
    localparam logic [4:0] OP_SLL  = 5'h07;
    localparam logic [4:0] OP_SRA  = 5'h09;
    localparam logic [4:0] OP_LUI  = 5'h0A;
    localparam logic [4:0] OP_SLT  = 5'h0B;
    localparam logic [4:0] OP_SLTU = 5'h0C;
    localparam logic [4:0] OP_DIV  = 5'h0D;
    localparam logic [4:0] OP_DIVU = 5'h0E;
    localparam logic [4:0] OP_REM  = 5'h0F;
    localparam logic [4:0] OP_REMU = 5'h10;
    localparam logic [4:0] OP_MUL  = 5'h11;
    localparam logic [4:0] OP_MULH = 5'h12;

    logic        clk;
    logic        rst;
    logic        iv32;
    logic        iv16;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    logic        in_ready, out_valid, busy;
    logic [31:0] alu_out;
    logic        in_ready16, out_valid16, busy16;
    logic [15:0] alu_out16;

    int n_cmp = 0;
    int n_err = 0;
    int edges;
    int ready_low;
    logic stale;

    mc_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .out_valid(out_valid), .alu_out(alu_out), .busy(busy)
    );

    mc_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(in_ready16),
        .alu_a(alu_a[15:0]), .alu_b(alu_b[15:0]), .alu_op(alu_op),
        .out_valid(out_valid16), .alu_out(alu_out16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic issue(input bit w16, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        if (w16) iv16 = 1'b1; else iv32 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        iv32 = 1'b0;
        edges     = 0;
        ready_low = 0;
        while (!(w16 ? out_valid16 : out_valid) && edges < 100) begin
            if (!(w16 ? in_ready16 : in_ready)) ready_low++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run(input string tag, input bit w16, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_edges);
        issue(w16, op, a, b);
        check({tag, "_val"}, w16 ? {48'h0, alu_out16} : {32'h0, alu_out}, {32'h0, exp});
        check({tag, "_lat"}, edges, exp_edges);
    endtask

    initial begin
        rst    = 1'b1;
        iv32   = 1'b0;
        iv16   = 1'b0;
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   in_ready,    1'b1);
        check("rst_out_valid",  out_valid,   1'b0);
        check("rst_alu_out",    alu_out,     32'h0);
        check("rst_busy",       busy,        1'b0);
        check("rst16_in_ready", in_ready16,  1'b1);
        check("rst16_alu_out",  alu_out16,   16'h0);
        rst = 1'b0;

        run("add_wrap", 0, OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
        run("sub_neg",  0, OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 0);
        run("xor",      0, OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0);
        run("nor",      0, OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 0);
        run("sll",      0, OP_SLL, 32'h4, 32'h1, 32'h10, 0);
        run("lui",      0, OP_LUI, 32'h0, 32'h0000_ABCD, 32'hABCD_0000, 0);
        run("slt",      0, OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
        run("unknown",  0, 5'h1F, 32'h1234, 32'h5678, 32'h0, 0);

        run("div_m7_2", 0, OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        check("div_ready_low", ready_low, 33);
        check("div_ready_at_result", in_ready, 1'b1);
        run("rem_m7_2", 0, OP_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
        run("div_7_m2", 0, OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run("rem_7_m2", 0, OP_REM, 32'h7, 32'hFFFF_FFFE, 32'h1, 33);

        run("divu_max_3", 0, OP_DIVU, 32'hFFFF_FFFF, 32'h3, 32'h5555_5555, 33);
        run("sra_b2b",    0, OP_SRA, 32'h4, 32'hF000_0000, 32'hFF00_0000, 0);
        run("remu_17_5",  0, OP_REMU, 32'd17, 32'd5, 32'd2, 33);

        run("div_by0",   0, OP_DIV, 32'h5, 32'h0, 32'h0, 0);
        run("rem_by0",   0, OP_REM, 32'h5, 32'h0, 32'h5, 0);
        run("div_ovf",   0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run("rem_ovf",   0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
`ifdef MC_ALU_MUL_EN
        run("mul",       0, OP_MUL, 32'd3, 32'd5, 32'd15, 0);
`else
        run("mul_off",   0, OP_MUL, 32'd3, 32'd5, 32'd0, 0);
`endif
        @(negedge clk);
        check("pulse_one_cycle", out_valid, 1'b0);

        // Reset lands at the tenth divider iteration.
        alu_op = OP_DIV;
        alu_a  = 32'd1000;
        alu_b  = 32'd7;
        iv32   = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        check("div_busy", busy, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready",  in_ready,  1'b1);
        check("midrst_busy",      busy,      1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_alu_out",   alu_out,   32'h0);
        stale = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("midrst_no_stale", stale, 1'b0);
        run("sltu_after_rst", 0, OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 0);

        run("w16_lui",  1, OP_LUI, 32'h0, 32'h0000_00AB, 32'h0000_AB00, 0);
        run("w16_div",  1, OP_DIV, 32'h0000_FFF9, 32'h0000_0002, 32'h0000_FFFD, 17);
`ifdef MC_ALU_MUL_EN
        run("w16_mulh", 1, OP_MULH, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 0);
`else
        run("w16_mulh", 1, OP_MULH, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
